// File: rtl/tsu_meas_sched.sv
// Measurement scheduler for the shared tsu phase datapath: round-robin grant, settle,
// per-sample vernier start with timeout, wrap-corrected averaging, one tagged response per grant.
module tsu_meas_sched #(
    parameter int NREQ          = 4,
    parameter int RAT_PREC_BITS = 32,
    parameter int TIMEOUT_BITS  = 16,
    parameter int AVG_LOG2      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_en,
    input  logic [NREQ-1:0]           i_req,
    input  logic [15:0]               i_settle_cycs,
    input  logic [TIMEOUT_BITS-1:0]   i_timeout_cycs,
    input  logic [RAT_PREC_BITS-1:0]  i_num,
    input  logic [RAT_PREC_BITS-1:0]  tsu_phase,
    input  logic                      tsu_phase_v,
    output logic                      vernier_start,
    output logic                      o_busy,
    output logic [NREQ-1:0]           o_gnt,
    output logic                      o_rsp_v,
    output logic [$clog2(NREQ)-1:0]   o_rsp_id,
    output logic [RAT_PREC_BITS-1:0]  o_rsp_phase,
    output logic                      o_rsp_err,
    output logic [7:0]                o_stray_cnt
);
    localparam int IDW   = $clog2(NREQ);
    localparam int EW    = RAT_PREC_BITS + 2;
    localparam int ACC_W = RAT_PREC_BITS + AVG_LOG2 + 2;
    localparam int NSAMP = 1 << AVG_LOG2;
    localparam int KW    = AVG_LOG2 + 1;

    typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, RESP} state_e;

    state_e                    state_q;
    logic [IDW-1:0]            ptr_q, gnt_idx_q, rsp_id_q;
    logic [15:0]               settle_q;
    logic [TIMEOUT_BITS-1:0]   tmo_q;
    logic [KW-1:0]             k_q;
    logic [RAT_PREC_BITS-1:0]  ref_q, rsp_phase_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      vs_q, busy_q, rsp_v_q, rsp_err_q;
    logic [NREQ-1:0]           gnt_q;
    logic [7:0]                stray_q;

    // First requester at or after the RR pointer: scan from the far end so the nearest wins.
    logic           pick_v;
    logic [IDW-1:0] pick_idx, ptr_d;
    logic [IDW:0]   arb_sum;
    always_comb begin
        pick_v   = 1'b0;
        pick_idx = '0;
        arb_sum  = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            arb_sum = {1'b0, ptr_q} + (IDW+1)'(off);
            if (arb_sum >= (IDW+1)'(NREQ))
                arb_sum = arb_sum - (IDW+1)'(NREQ);
            if (i_req[arb_sum[IDW-1:0]]) begin
                pick_v   = 1'b1;
                pick_idx = arb_sum[IDW-1:0];
            end
        end
        ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    end

    // Unwrap each sample towards the reference so samples straddling 0/i_num average sanely.
    logic signed [EW-1:0]    s_x, f_x, n_x, h_x, corr;
    logic signed [ACC_W-1:0] acc_d, avg_s, n_a, avg_w;
    logic                    unused_hi;
    always_comb begin
        s_x = $signed(EW'(tsu_phase));
        f_x = (k_q == '0) ? s_x : $signed(EW'(ref_q));
        n_x = $signed(EW'(i_num));
        h_x = $signed(EW'(i_num >> 1));
        if (s_x - f_x > h_x)
            corr = s_x - n_x;
        else if (f_x - s_x > h_x)
            corr = s_x + n_x;
        else
            corr = s_x;
        acc_d = acc_q + ACC_W'(corr);
        avg_s = acc_d >>> AVG_LOG2;
        n_a   = $signed(ACC_W'(i_num));
        if (avg_s[ACC_W-1])
            avg_w = avg_s + n_a;
        else if (avg_s >= n_a)
            avg_w = avg_s - n_a;
        else
            avg_w = avg_s;
    end
    assign unused_hi = ^avg_w[ACC_W-1:RAT_PREC_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            rsp_id_q    <= '0;
            settle_q    <= '0;
            tmo_q       <= '0;
            k_q         <= '0;
            ref_q       <= '0;
            acc_q       <= '0;
            vs_q        <= 1'b0;
            busy_q      <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_phase_q <= '0;
            gnt_q       <= '0;
            stray_q     <= '0;
        end else begin
            vs_q    <= 1'b0;
            rsp_v_q <= 1'b0;
            if (tsu_phase_v && state_q != WAIT && stray_q != 8'hFF)
                stray_q <= stray_q + 8'd1;
            case (state_q)
                IDLE: if (i_en && pick_v) begin
                    state_q   <= SETTLE;
                    busy_q    <= 1'b1;
                    gnt_q     <= NREQ'(1) << pick_idx;
                    gnt_idx_q <= pick_idx;
                    ptr_q     <= ptr_d;
                    settle_q  <= i_settle_cycs;
                    acc_q     <= '0;
                    k_q       <= '0;
                end
                SETTLE: if (settle_q <= 16'd1) begin
                    state_q <= START;
                    vs_q    <= 1'b1;
                end else begin
                    settle_q <= settle_q - 16'd1;
                end
                START: begin
                    tmo_q   <= i_timeout_cycs;
                    state_q <= WAIT;
                end
                WAIT: if (tsu_phase_v) begin
                    acc_q <= acc_d;
                    k_q   <= k_q + KW'(1);
                    if (k_q == '0)
                        ref_q <= tsu_phase;
                    if (k_q == KW'(NSAMP - 1)) begin
                        state_q     <= RESP;
                        rsp_v_q     <= 1'b1;
                        rsp_id_q    <= gnt_idx_q;
                        rsp_phase_q <= avg_w[RAT_PREC_BITS-1:0];
                        rsp_err_q   <= 1'b0;
                    end else begin
                        state_q <= START;
                        vs_q    <= 1'b1;
                    end
                end else if (tmo_q <= TIMEOUT_BITS'(1)) begin
                    state_q     <= RESP;
                    rsp_v_q     <= 1'b1;
                    rsp_id_q    <= gnt_idx_q;
                    rsp_phase_q <= '0;
                    rsp_err_q   <= 1'b1;
                end else begin
                    tmo_q <= tmo_q - TIMEOUT_BITS'(1);
                end
                RESP: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    gnt_q       <= '0;
                    rsp_id_q    <= '0;
                    rsp_phase_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vernier_start = vs_q;
    assign o_busy        = busy_q;
    assign o_gnt         = gnt_q;
    assign o_rsp_v       = rsp_v_q;
    assign o_rsp_id      = rsp_id_q;
    assign o_rsp_phase   = rsp_phase_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_stray_cnt   = stray_q;
endmodule
